// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types and encodings for the GCD controller slice
//
// Purpose: FSM state enum, mux select encodings and default datapath width
//          shared by the controller, its interface and the testbench.
// Ports:   none (package).
package gcd_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        RUN,
        DONE
    } gcd_state_e;

    // Subtractor operand selects (sel1 = minuend, sel2 = subtrahend).
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Register load bus select.
    localparam logic SEL_BUS_SUB = 1'b0;
    localparam logic SEL_BUS_IN  = 1'b1;

endpackage

// File: rtl/gcd_controller_if.sv
// rtl/gcd_controller_if.sv - handshake, datapath control and status bundle
//
// Purpose: groups every non-clock/reset signal of gcd_controller.
// Modports:
//   master - the controller: consumes start/in_valid/gt/lt/eq, drives
//            in_ready, ldA/ldB, sel1/sel2/sel_in, busy/done/timeout/iter_count.
//   slave  - the system and datapath side, the mirror image of master.
interface gcd_controller_if #(
    parameter int ITER_W = 16
);

    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              gt;
    logic              lt;
    logic              eq;
    logic              ldA;
    logic              ldB;
    logic              sel1;
    logic              sel2;
    logic              sel_in;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [ITER_W-1:0] iter_count;

    modport master (
        input  start, in_valid, gt, lt, eq,
        output in_ready, ldA, ldB, sel1, sel2, sel_in,
        output busy, done, timeout, iter_count
    );

    modport slave (
        output start, in_valid, gt, lt, eq,
        input  in_ready, ldA, ldB, sel1, sel2, sel_in,
        input  busy, done, timeout, iter_count
    );

endinterface

// File: rtl/gcd_iter_counter.sv
// rtl/gcd_iter_counter.sv - saturating subtraction-cycle counter with limit flag
//
// Purpose: counts subtraction cycles of one GCD run; built only when
//          GCD_CTRL_TIMEOUT_EN is defined.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - zero the count (start of a new run)
//   inc       - count one subtraction cycle
//   count     - current count, saturates at all-ones
//   at_limit  - count has reached MAX_ITER
`ifdef GCD_CTRL_TIMEOUT_EN
module gcd_iter_counter #(
    parameter int          ITER_W   = 16,
    parameter int unsigned MAX_ITER = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ITER_W-1:0] count,
    output logic              at_limit
);

    localparam logic [ITER_W-1:0] LIMIT = ITER_W'(MAX_ITER);
    localparam logic [ITER_W-1:0] SAT   = '1;

    logic [ITER_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != SAT)) begin
            count_d = count_q + ITER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign at_limit = (count_q == LIMIT);

endmodule
`endif

// File: rtl/gcd_controller.sv
// rtl/gcd_controller.sv - control FSM for the subtractive GCD datapath
//
// Purpose: loads operands A then B over a valid/ready handshake, then issues
//          one subtraction per cycle until the datapath reports A == B.
//          Optional macro GCD_CTRL_TIMEOUT_EN adds the iteration counter and
//          the MAX_ITER abort (timeout); without it iter_count/timeout are 0.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - gcd_controller_if.master: start/in_valid/in_ready handshake,
//          gt/lt/eq flags, ldA/ldB/sel1/sel2/sel_in controls,
//          busy/done/timeout/iter_count status
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int          ITER_W   = 16,
    parameter int unsigned MAX_ITER = 16'hFFFF
) (
    input  logic                clk,
    input  logic                rst,
    gcd_controller_if.master    bus
);

    gcd_state_e        state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              cnt_clr, cnt_inc;
    logic              at_limit;
    logic [ITER_W-1:0] iter_count;
    logic              one_flag;

    // A decision is only trusted when exactly one flag is set; anything else
    // terminates the run so a broken datapath cannot stall the FSM.
    assign one_flag = ($countones({bus.gt, bus.lt, bus.eq}) == 1);

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = done_q;
        timeout_d    = timeout_q;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        bus.in_ready = 1'b0;
        bus.ldA      = 1'b0;
        bus.ldB      = 1'b0;
        bus.sel1     = SEL_A;
        bus.sel2     = SEL_A;
        bus.sel_in   = SEL_BUS_IN;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d   = LOAD_A;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    cnt_clr   = 1'b1;
                end
            end
            LOAD_A: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    bus.ldA = 1'b1;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    bus.ldB = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.eq || !one_flag) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (at_limit) begin
                    // Limit reached without convergence: abort, no load.
                    state_d   = DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else if (bus.gt) begin
                    bus.ldA    = 1'b1;
                    bus.sel_in = SEL_BUS_SUB;
                    bus.sel1   = SEL_A;
                    bus.sel2   = SEL_B;
                    cnt_inc    = 1'b1;
                end else begin
                    bus.ldB    = 1'b1;
                    bus.sel_in = SEL_BUS_SUB;
                    bus.sel1   = SEL_B;
                    bus.sel2   = SEL_A;
                    cnt_inc    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef GCD_CTRL_TIMEOUT_EN
    gcd_iter_counter #(
        .ITER_W   (ITER_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .count    (iter_count),
        .at_limit (at_limit)
    );
`else
    // No counter: RUN leaves only on a terminating flag decision.
    assign iter_count = '0;
    assign at_limit   = 1'b0;
    logic unused_cnt;
    assign unused_cnt = ^{cnt_clr, cnt_inc, MAX_ITER};
`endif

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.timeout    = timeout_q;
    assign bus.iter_count = iter_count;

endmodule

// File: doc/gcd_controller.md
Name: gcd_controller

Overview:
- Control FSM for the subtractive GCD datapath. It sits directly upstream of that datapath, drives its load and mux selects, and consumes its gt/lt/eq compare flags.
- It sequences the operand loads from data_in using a valid/ready handshake, then runs one subtraction per cycle until the flags report equality.
- It reports done/busy to the system and bounds the run with an iteration limit, so a zero operand cannot hang the block.

Parameters:
- ITER_W, 16, width of the iteration counter.
- MAX_ITER, 16'hFFFF, number of subtraction cycles after which the run aborts with timeout.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a GCD computation. Accepted only in IDLE or DONE.
- in_valid  input  1  data_in holds a valid operand this cycle.
- in_ready  output  1  controller will capture data_in this cycle (LOAD_A/LOAD_B).
- gt  input  1  datapath flag, A > B.
- lt  input  1  datapath flag, A < B.
- eq  input  1  datapath flag, A == B.
- ldA  output  1  load register A.
- ldB  output  1  load register B.
- sel1  output  1  subtractor minuend select: 0 = A, 1 = B.
- sel2  output  1  subtractor subtrahend select: 0 = A, 1 = B.
- sel_in  output  1  load bus select: 1 = data_in, 0 = subtractor output.
- busy  output  1  high from start acceptance until DONE/IDLE.
- done  output  1  result valid in register A. Held high until the next accepted start or rst.
- timeout  output  1  run aborted at MAX_ITER. Held with done.
- iter_count  output  ITER_W  subtraction cycles performed in the current or last run.

Behaviour:
- States: IDLE, LOAD_A, LOAD_B, RUN, DONE.
- Reset: state = IDLE; busy = done = timeout = 0; iter_count = 0.
- Control outputs are a combinational decode of state and inputs. Outside the cases listed below, ldA = ldB = 0, sel1 = sel2 = 0, sel_in = 1, in_ready = 0.
- IDLE or DONE, start = 1:
  - go to LOAD_A;
  - clear done, timeout and iter_count;
  - set busy.
- LOAD_A:
  - in_ready = 1, sel_in = 1.
  - If in_valid: ldA = 1, next state LOAD_B.
  - Otherwise wait indefinitely.
- LOAD_B: same as LOAD_A, but asserts ldB and goes to RUN.
- RUN (the compare flags reflect the registered A/B, so one decision per cycle):
  - eq → DONE; no load this cycle.
  - gt → ldA = 1, sel_in = 0, sel1 = 0, sel2 = 1 (A ← A − B); iter_count + 1.
  - lt → ldB = 1, sel_in = 0, sel1 = 1, sel2 = 0 (B ← B − A); iter_count + 1.
- Timeout: if iter_count == MAX_ITER at entry to a RUN cycle without eq, no load is issued, timeout is set and the state goes to DONE.
- Entering DONE: busy falls and done rises on the same edge. Register A holds the GCD unless timeout is set.
- Latency: 2 load cycles (minimum, in_valid held high) + N subtraction cycles + 1 eq-detect cycle, then done.
- Ignored inputs:
  - start while busy is ignored;
  - in_valid outside LOAD_A/LOAD_B is ignored.
- Illegal flag combinations in RUN (none set, or more than one set): treated as eq (terminate) so the FSM cannot stall.
- rst mid-operation returns the block to IDLE in one cycle, and all outputs take their reset values. Datapath register contents are don't-care after this.
- iter_count saturates; it never wraps.

Optional Feature:
- Macro: GCD_CTRL_TIMEOUT_EN.
- Defined: iteration counter, MAX_ITER abort and the timeout output are active as described above.
- Undefined:
  - the counter logic is removed;
  - iter_count and timeout are tied to 0;
  - RUN exits only on eq (a zero operand hangs until rst);
  - MAX_ITER is unused.

Decomposition:
- Shared package gcd_pkg:
  - state enum (IDLE, LOAD_A, LOAD_B, RUN, DONE);
  - select encodings SEL_A = 0, SEL_B = 1, SEL_BUS_SUB = 0, SEL_BUS_IN = 1;
  - default DATA_W = 16.
- One sub-module, gcd_iter_counter: clear, increment enable, saturate, limit-reached flag. Compiled only under GCD_CTRL_TIMEOUT_EN.

Test Plan:
- Operands 48, 18 with in_valid held high → 4 subtraction cycles (30/18, 12/18, 12/6, 6/6); done at the 7th cycle after start; A = 6; iter_count = 4; timeout = 0.
- Operands 7, 7 → RUN sees eq immediately; iter_count = 0; done after 3 cycles; A = 7.
- MAX_ITER = 16, operands 5, 0 → 16 subtractions, then done = 1, timeout = 1, iter_count = 16. With the macro undefined, busy stays high for 100+ cycles until rst.
- in_valid gated low for 3 cycles in LOAD_A and 2 in LOAD_B → in_ready held high throughout; ldA/ldB pulse exactly once each; result 21, 14 → 7.
- start pulsed during RUN for 1071, 462 → ignored; result 21 unchanged. A second start after done → done clears next cycle and a new run begins.
- rst asserted during RUN → next cycle state IDLE, busy = done = timeout = 0, iter_count = 0, all loads deasserted.
